mem_load_tracker: RTL

- Sits directly downstream of the LSQ, between its memory request port and the 64-bit memory bus.
- Forwards one load or store per cycle to memory and records each accepted load against the tag memory returns.
- On tagged data return, extracts the addressed bytes, sign- or zero-extends them, and presents a completion to the LSQ/CDB.
- Supports out-of-order returns and a branch-recovery squash.

---
 rtl/mem_load_tracker_pkg.sv | 33 +++
 rtl/mem_load_tracker_align.sv | 25 ++
 rtl/mem_load_tracker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_load_tracker_pkg.sv
// Shared types and sizing for the LSQ-to-memory load tracker.
package mem_load_tracker_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned PREG_W      = 6;
    localparam int unsigned NUM_ENTRIES = 4;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } bus_command_e;

    typedef struct packed {
        logic              valid;
        logic              squashed;
        logic [TAG_W-1:0]  tag;
        logic [PREG_W-1:0] dest;
        logic [2:0]        offset;
        mem_size_e         size;
        logic              is_unsigned;
    } load_slot_t;

endpackage

// File: rtl/mem_load_tracker_align.sv
// Picks the addressed bytes out of a 64-bit bus word and extends them to XLEN.
module load_data_align
    import mem_load_tracker_pkg::*;
(
    input  logic [63:0]     data,
    input  logic [2:0]      offset,
    input  mem_size_e       size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [63:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = shifted[XLEN-1:0];
        case (size)
            BYTE:    result = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            HALF:    result = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: result = shifted[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/mem_load_tracker.sv
// Forwards LSQ requests to the memory bus and tracks outstanding loads by tag,
// producing extended load completions as tagged data returns.
module mem_load_tracker
    import mem_load_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic              req_is_store_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [PREG_W-1:0] req_dest_reg_i,
    output logic              req_ready_o,
    input  logic              flush_i,
    output logic [1:0]        mem_command_o,
    output logic [XLEN-1:0]   mem_address_o,
    output logic [2:0]        mem_size_o,
    output logic [63:0]       mem_wdata_o,
    input  logic [TAG_W-1:0]  mem_response_i,
    input  logic [TAG_W-1:0]  mem_tag_i,
    input  logic [63:0]       mem_data_i,
    output logic              done_o,
    output logic [PREG_W-1:0] dest_reg_o,
    output logic [XLEN-1:0]   result_o,
    output logic              full_o
);

    load_slot_t       slots      [NUM_ENTRIES];
    load_slot_t       slots_next [NUM_ENTRIES];
    bus_command_e     cmd;
    logic             full;
    logic             alloc;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             complete;
    logic [XLEN-1:0]  aligned;

    // Occupancy, lowest free slot and tag match, all from pre-edge state
    always_comb begin
        full     = 1'b1;
        free_idx = '0;
        hit      = 1'b0;
        hit_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            full = full & slots[i].valid;
            if (!slots[i].valid) begin
                free_idx = IDX_W'(i);
            end
            if (slots[i].valid && (mem_tag_i != '0) && (slots[i].tag == mem_tag_i)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign full_o = full;

    // Bus issue is purely combinational; the LSQ holds the request until ready
    always_comb begin
        cmd           = NONE;
        mem_address_o = '0;
        mem_size_o    = 3'd0;
        mem_wdata_o   = '0;
        if (reset && req_valid_i && !flush_i) begin
            if (req_is_store_i) begin
                cmd           = STORE;
                mem_address_o = req_addr_i;
                mem_size_o    = 3'(req_size_i);
                mem_wdata_o   = 64'(req_wdata_i);
            end else if (!full) begin
                cmd           = LOAD;
                mem_address_o = {req_addr_i[XLEN-1:3], 3'b000};
                mem_size_o    = 3'(DOUBLE);
            end
        end
    end

    assign mem_command_o = cmd;
    assign req_ready_o   = (cmd != NONE) && (mem_response_i != '0);
    assign alloc         = req_ready_o && (cmd == LOAD);
    assign complete      = hit && !slots[hit_idx].squashed && !flush_i;

    // Allocation never targets the matched slot since that slot is still valid pre-edge
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            slots_next[i] = slots[i];
            if (flush_i && slots[i].valid) begin
                slots_next[i].squashed = 1'b1;
            end
            if (hit && (hit_idx == IDX_W'(i))) begin
                slots_next[i].valid = 1'b0;
            end
            if (alloc && (free_idx == IDX_W'(i))) begin
                slots_next[i].valid       = 1'b1;
                slots_next[i].squashed    = 1'b0;
                slots_next[i].tag         = mem_response_i;
                slots_next[i].dest        = req_dest_reg_i;
                slots_next[i].offset      = req_addr_i[2:0];
                slots_next[i].size        = mem_size_e'(req_size_i);
                slots_next[i].is_unsigned = req_unsigned_i;
            end
        end
    end

    load_data_align u_align (
        .data        (mem_data_i),
        .offset      (slots[hit_idx].offset),
        .size        (slots[hit_idx].size),
        .is_unsigned (slots[hit_idx].is_unsigned),
        .result      (aligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slots[i] <= '0;
            end
            done_o     <= 1'b0;
            dest_reg_o <= '0;
            result_o   <= '0;
        end else begin
            slots  <= slots_next;
            done_o <= complete;
            if (complete) begin
                dest_reg_o <= slots[hit_idx].dest;
                result_o   <= aligned;
            end
        end
    end

endmodule
